// File: rtl/sub_operand_sequencer.sv
// ---------------------------------------------------------------------------
// sub_operand_sequencer
//
// Purpose:
//   Sequential front/back-end for an external combinational WIDTH-bit
//   subtracter. Bytes arrive over a valid/ready stream and are paired:
//   the first byte of a pair becomes operand A and the second becomes
//   operand B. Both operands are registered and driven onto the
//   subtracter. The returned difference is captured one settle cycle
//   later. The borrow is computed locally as (A < B), unsigned. The
//   {difference, borrow} result is then offered downstream over a second
//   valid/ready handshake.
//
//   The input phase and the output phase never overlap. At most one
//   result is produced every four cycles.
//
// Configuration:
//   SUB_SATURATE_EN - when defined, a subtraction that would wrap
//                     (A < B) yields a difference of 0 instead of the
//                     modulo result. The borrow is still reported.
//                     Handshake timing and the pair counter are the same
//                     in both builds.
//
// Parameters:
//   WIDTH - operand, difference and stream data width in bits
//   CNT_W - width of the completed-pair counter
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   in_valid   in   upstream byte valid
//   in_data    in   upstream byte (first of pair = A, second = B)
//   in_ready   out  stage can accept a byte (LOAD_A/LOAD_B, not in reset)
//   sub_a      out  registered operand A to the subtracter
//   sub_b      out  registered operand B to the subtracter
//   sub_diff   in   difference returned by the subtracter
//   out_valid  out  result valid
//   out_diff   out  captured difference
//   out_borrow out  1 when A < B (unsigned)
//   out_ready  in   downstream accepts the result
//   pair_count out  results accepted downstream, saturating at all-ones
// ---------------------------------------------------------------------------
module sub_operand_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] sub_a,
    output logic [WIDTH-1:0] sub_b,
    input  logic [WIDTH-1:0] sub_diff,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_diff,
    output logic             out_borrow,
    input  logic             out_ready,
    output logic [CNT_W-1:0] pair_count
);

    // -----------------------------------------------------------------------
    // State encoding
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        SAMPLE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    // Registered datapath
    logic [WIDTH-1:0] sub_a_q;
    logic [WIDTH-1:0] sub_a_d;
    logic [WIDTH-1:0] sub_b_q;
    logic [WIDTH-1:0] sub_b_d;
    logic [WIDTH-1:0] out_diff_q;
    logic [WIDTH-1:0] out_diff_d;
    logic             out_borrow_q;
    logic             out_borrow_d;
    logic             out_valid_q;
    logic             out_valid_d;
    logic [CNT_W-1:0] pair_count_q;
    logic [CNT_W-1:0] pair_count_d;

    // Handshake decode
    logic             in_ready_c;
    logic             in_xfer;
    logic             out_xfer;

    // Result selection
    logic             a_lt_b;
    logic [WIDTH-1:0] sample_diff;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD_A;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // SAMPLE always lasts exactly one cycle so the external subtracter
    // has a full clock period to settle on the freshly registered operands.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOAD_A: begin
                if (in_xfer) begin
                    state_d = LOAD_B;
                end
            end
            LOAD_B: begin
                if (in_xfer) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (out_xfer) begin
                    state_d = LOAD_A;
                end
            end
            default: begin
                state_d = LOAD_A;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output / handshake decode
    // in_ready is gated by rst so that no byte appears to be accepted while
    // the stage is being reset, even though reset wins at the edge anyway.
    // -----------------------------------------------------------------------
    always_comb begin
        in_ready_c = 1'b0;
        in_xfer    = 1'b0;
        out_xfer   = 1'b0;
        if (!rst && (state_q == LOAD_A || state_q == LOAD_B)) begin
            in_ready_c = 1'b1;
        end
        in_xfer  = in_valid && in_ready_c;
        out_xfer = (state_q == HOLD) && out_valid_q && out_ready;
    end

    // -----------------------------------------------------------------------
    // Borrow and difference selection
    // The borrow comes from a local compare of the registered operands; the
    // subtracter's own carry is not trusted or needed.
    // -----------------------------------------------------------------------
    always_comb begin
        a_lt_b      = (sub_a_q < sub_b_q);
        sample_diff = sub_diff;
`ifdef SUB_SATURATE_EN
        if (a_lt_b) begin
            sample_diff = '0;
        end
`endif
    end

    // -----------------------------------------------------------------------
    // Datapath next values
    // Operands change only on their own load transfer, so they stay stable
    // on the subtracter inputs through SAMPLE and HOLD. The captured result
    // is frozen from SAMPLE until the downstream transfer.
    // -----------------------------------------------------------------------
    always_comb begin
        sub_a_d      = sub_a_q;
        sub_b_d      = sub_b_q;
        out_diff_d   = out_diff_q;
        out_borrow_d = out_borrow_q;
        out_valid_d  = out_valid_q;
        pair_count_d = pair_count_q;

        if (state_q == LOAD_A && in_xfer) begin
            sub_a_d = in_data;
        end

        if (state_q == LOAD_B && in_xfer) begin
            sub_b_d = in_data;
        end

        if (state_q == SAMPLE) begin
            out_diff_d   = sample_diff;
            out_borrow_d = a_lt_b;
            out_valid_d  = 1'b1;
        end

        // The counter sticks at all-ones rather than wrapping back to zero.
        if (out_xfer) begin
            out_valid_d = 1'b0;
            if (pair_count_q != {CNT_W{1'b1}}) begin
                pair_count_d = pair_count_q + CNT_W'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // Reset drops any partial pair or pending result without counting it.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sub_a_q      <= '0;
            sub_b_q      <= '0;
            out_diff_q   <= '0;
            out_borrow_q <= 1'b0;
            out_valid_q  <= 1'b0;
            pair_count_q <= '0;
        end else begin
            sub_a_q      <= sub_a_d;
            sub_b_q      <= sub_b_d;
            out_diff_q   <= out_diff_d;
            out_borrow_q <= out_borrow_d;
            out_valid_q  <= out_valid_d;
            pair_count_q <= pair_count_d;
        end
    end

    // -----------------------------------------------------------------------
    // Port drivers
    // -----------------------------------------------------------------------
    always_comb begin
        in_ready   = in_ready_c;
        sub_a      = sub_a_q;
        sub_b      = sub_b_q;
        out_valid  = out_valid_q;
        out_diff   = out_diff_q;
        out_borrow = out_borrow_q;
        pair_count = pair_count_q;
    end

endmodule
